// File: rtl/tail_light_sequencer.sv
// rtl/tail_light_sequencer.sv - six-lamp turn/hazard tail-light sequencer
// Optional brake overlay enabled by defining BRAKE_OVERLAY_EN.
module tail_light_sequencer #(
  parameter int STEP_CYCLES = 3,
  parameter int CNT_W       = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  input  logic       brake,
  output logic [5:0] light_out,
  output logic       busy,
  output logic       seq_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HZ_ON, S_HZ_OFF
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       light_q, light_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             haz, step_end;

  assign haz      = hazard_req | (left_req & right_req);
  assign step_end = (cnt_q == CNT_W'(STEP_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    done_d  = 1'b0;
    light_d = 6'b000000;
    busy_d  = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (haz)            state_d = S_HZ_ON;
        else if (left_req)  state_d = S_L1;
        else if (right_req) state_d = S_R1;
      end
      S_L1: if (haz) state_d = S_HZ_ON; else if (step_end) state_d = S_L2;
      S_L2: if (haz) state_d = S_HZ_ON; else if (step_end) state_d = S_L3;
      S_R1: if (haz) state_d = S_HZ_ON; else if (step_end) state_d = S_R2;
      S_R2: if (haz) state_d = S_HZ_ON; else if (step_end) state_d = S_R3;
      S_L3, S_R3: begin
        if (haz) begin
          state_d = S_HZ_ON;
        end else if (step_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_HZ_ON:  if (!haz) state_d = S_IDLE; else if (step_end) state_d = S_HZ_OFF;
      S_HZ_OFF: if (!haz) state_d = S_IDLE; else if (step_end) state_d = S_HZ_ON;
      default:  state_d = S_IDLE;
    endcase

    // Counter restarts on every state change; never passes STEP_CYCLES-1.
    if (state_d == state_q && state_q != S_IDLE) cnt_d = cnt_q + 1'b1;

    case (state_d)
      S_L1:    light_d = 6'b001000;
      S_L2:    light_d = 6'b011000;
      S_L3:    light_d = 6'b111000;
      S_R1:    light_d = 6'b000100;
      S_R2:    light_d = 6'b000110;
      S_R3:    light_d = 6'b000111;
      S_HZ_ON: light_d = 6'b111111;
      default: light_d = 6'b000000;
    endcase
    if (state_d == S_IDLE) busy_d = 1'b0;

`ifdef BRAKE_OVERLAY_EN
    if (brake) begin
      case (state_d)
        S_IDLE:             light_d = 6'b111111;
        S_L1, S_L2, S_L3:   light_d = light_d | 6'b000111;
        S_R1, S_R2, S_R3:   light_d = light_d | 6'b111000;
        default:            light_d = light_d;
      endcase
    end
`endif
  end

`ifndef BRAKE_OVERLAY_EN
  logic unused_brake;
  assign unused_brake = brake;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      light_q <= 6'b000000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      light_q <= light_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign light_out = light_q;
  assign busy      = busy_q;
  assign seq_done  = done_q;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// tb/tb_tail_light_sequencer.sv - randomized bench with behavioural lamp model
module tb_tail_light_sequencer;

  localparam int STEP = 3;

  logic       clk = 1'b0;
  logic       reset, left_req, right_req, hazard_req, brake;
  logic [5:0] light_out;
  logic       busy, seq_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: activity kind (0 idle, 1 left, 2 right, 3 hazard), lit step, cycles spent in step
  int m_kind, m_pos, m_elapsed;
  bit m_done;

  tail_light_sequencer #(.STEP_CYCLES(STEP), .CNT_W(11)) dut (
    .clk(clk), .reset(reset), .left_req(left_req), .right_req(right_req),
    .hazard_req(hazard_req), .brake(brake),
    .light_out(light_out), .busy(busy), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_lamps(input bit brk);
    logic [5:0] l;
    l = 6'b0;
    if (m_kind == 1) l = 6'(((1 << (m_pos + 1)) - 1) << 3);
    if (m_kind == 2) l = 6'((7 << (2 - m_pos)) & 7);
    if (m_kind == 3 && m_pos == 0) l = 6'b111111;
`ifdef BRAKE_OVERLAY_EN
    if (brk && m_kind == 0) l = 6'b111111;
    if (brk && m_kind == 1) l = l | 6'b000111;
    if (brk && m_kind == 2) l = l | 6'b111000;
`endif
    return l;
  endfunction

  task automatic model_step(input bit rst, input bit lr, input bit rr, input bit hr);
    bit haz;
    haz    = hr | (lr & rr);
    m_done = 0;
    if (rst) begin
      m_kind = 0; m_pos = 0; m_elapsed = 0;
    end else if (haz && m_kind != 3) begin
      m_kind = 3; m_pos = 0; m_elapsed = 0;
    end else if (m_kind == 3) begin
      if (!haz) begin
        m_kind = 0; m_pos = 0; m_elapsed = 0;
      end else if (m_elapsed == STEP - 1) begin
        m_pos = 1 - m_pos; m_elapsed = 0;
      end else m_elapsed++;
    end else if (m_kind != 0) begin
      if (m_elapsed < STEP - 1) m_elapsed++;
      else if (m_pos == 2) begin
        m_kind = 0; m_pos = 0; m_elapsed = 0; m_done = 1;
      end else begin
        m_pos++; m_elapsed = 0;
      end
    end else if (lr) begin
      m_kind = 1; m_pos = 0; m_elapsed = 0;
    end else if (rr) begin
      m_kind = 2; m_pos = 0; m_elapsed = 0;
    end
  endtask

  task automatic cycle(input string tag);
    bit s_rst, s_l, s_r, s_h, s_b;
    @(posedge clk);
    s_rst = reset; s_l = left_req; s_r = right_req; s_h = hazard_req; s_b = brake;
    model_step(s_rst, s_l, s_r, s_h);
    #1;
    chk({tag, ".light"}, {2'b0, light_out}, {2'b0, model_lamps(s_b)});
    chk({tag, ".busy"}, {7'b0, busy}, {7'b0, m_kind != 0});
    chk({tag, ".done"}, {7'b0, seq_done}, {7'b0, m_done});
  endtask

  int hold;
  int mode;

  initial begin
    m_kind = 0; m_pos = 0; m_elapsed = 0; m_done = 0;
    reset = 1; left_req = 0; right_req = 0; hazard_req = 0; brake = 0;
    cycle("reset");
    cycle("reset");
    chk("reset_light_const", {2'b0, light_out}, 8'h00);
    reset = 0;

    // Single-cycle left pulse: full 9-cycle sequence then done pulse
    left_req = 1;
    cycle("left_pulse");
    left_req = 0;
    for (int i = 0; i < 11; i++) cycle("left_seq");

    // Held right request repeats with a 10-cycle period
    right_req = 1;
    for (int i = 0; i < 25; i++) cycle("right_held");
    right_req = 0;
    for (int i = 0; i < 10; i++) cycle("right_tail");

    // Hazard preempting L2, then release
    left_req = 1;
    cycle("haz_pre");
    left_req = 0;
    for (int i = 0; i < 4; i++) cycle("haz_pre");
    hazard_req = 1;
    for (int i = 0; i < 10; i++) cycle("haz_blink");
    hazard_req = 0;
    cycle("haz_release");
    chk("haz_release_idle", {2'b0, light_out}, 8'h00);

    // Randomized segments of held input combinations, occasional reset
    for (int seg = 0; seg < 300; seg++) begin
      mode = $urandom_range(0, 9);
      hold = $urandom_range(1, 14);
      left_req   = (mode == 1 || mode == 2 || mode == 6);
      right_req  = (mode == 3 || mode == 4 || mode == 6);
      hazard_req = (mode == 5);
      brake      = $urandom_range(0, 2) == 0;
      reset      = $urandom_range(0, 24) == 0;
      for (int c = 0; c < hold; c++) begin
        cycle("rand");
        reset = 0;
        if (mode == 2 || mode == 4) begin
          left_req = 0; right_req = 0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tail_light_sequencer.md
Name: tail_light_sequencer

Overview:
Controller for the six-lamp tail-light bank (L3 L2 L1 | R1 R2 R3, light_out[5:3] = L3..L1, light_out[2:0] = R1..R3).
- Arbitrates among left-turn, right-turn, hazard and brake requests.
- Times each animation step with a programmable step counter.
- Drives the registered 6-bit lamp vector and a sequence-complete pulse for the body-control logic.

Parameters:
STEP_CYCLES, 3, clock cycles each animation step is held (legal range 1..2^CNT_W-1)
CNT_W, 11, width of the step counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
left_req  input  1  left turn request, level
right_req  input  1  right turn request, level
hazard_req  input  1  hazard request, level
brake  input  1  brake pedal, level (used only with BRAKE_OVERLAY_EN)
light_out  output  6  lamp drive {L3,L2,L1,R1,R2,R3}, registered
busy  output  1  high in any state other than IDLE, registered
seq_done  output  1  one-cycle pulse on the edge a turn sequence leaves L3 or R3, registered

Behaviour:
- Reset: reset=1 at an edge forces state IDLE, counter 0, light_out=000000, busy=0, seq_done=0. This holds from any state, including mid-sequence and mid-hazard.
- Hazard condition: haz = hazard_req | (left_req & right_req).
- States and patterns:
  - IDLE 000000
  - L1 001000, L2 011000, L3 111000
  - R1 000100, R2 000110, R3 000111
  - HZ_ON 111111, HZ_OFF 000000
- Outputs are registered with the state: light_out, busy and seq_done take the new state's values on the same edge the state changes. No extra latency.
- Step counter:
  - Cleared on every state change.
  - Otherwise increments each cycle while in a timed state (L*, R*, HZ_*).
  - Step end = counter equals STEP_CYCLES-1. Each timed state therefore lasts exactly STEP_CYCLES cycles.
- Priority, evaluated every cycle: reset > haz > current sequence > new left/right request.
- Transitions from IDLE:
  - haz → HZ_ON.
  - Otherwise left_req → L1.
  - Otherwise right_req → R1.
  - Otherwise stay in IDLE.
- Left sequence: L1→L2→L3 at each step end. At step end in L3 → IDLE with seq_done=1 for that one cycle. Right sequence is identical (R1→R2→R3→IDLE).
- Requests are sampled only in IDLE. Deasserting left_req or right_req mid-sequence does not abort the sequence; a right_req during a left sequence is ignored.
- Held request repeats: one full turn cycle is 3*STEP_CYCLES cycles in L/R states plus 1 cycle in IDLE.
- haz asserted in any L/R state preempts on the next edge → HZ_ON, counter cleared, no seq_done.
- Hazard blinking: HZ_ON↔HZ_OFF toggles at each step end while haz=1. When haz=0 in either hazard state → IDLE on the next edge, regardless of counter value.
- Counter width: counter never exceeds STEP_CYCLES-1, so no wrap-around occurs. With STEP_CYCLES=1, every timed state lasts one cycle.

Optional Feature:
BRAKE_OVERLAY_EN
- Defined:
  - brake=1 forces lamps not owned by an active turn sequence to on. In IDLE, light_out=111111. In L*, right half = 111 (e.g. L1 → 001111). In R*, left half = 111.
  - Hazard states ignore brake.
  - The overlay is applied in the same registered update as the state, so brake changes appear one edge after sampling.
- Undefined: brake is ignored and patterns are exactly as listed above.

Test Plan:
1. STEP_CYCLES=3, reset then left_req=1 for 1 cycle → light_out 001000 x3, 011000 x3, 111000 x3, then 000000 with seq_done=1 for 1 cycle; busy=1 for those 9 cycles.
2. right_req held high for 25 cycles → patterns 000100/000110/000111 repeat with period 10 cycles; seq_done pulses on cycles 10 and 20.
3. left_req=1, then hazard_req=1 during L2 → next edge light_out=111111; then alternates 111111/000000 every 3 cycles; no seq_done; hazard_req=0 → 000000 on the next edge.
4. left_req and right_req both high from IDLE → HZ_ON (111111), same blink as scenario 3; both dropped → IDLE.
5. Reset asserted in R3 and in HZ_ON → next edge light_out=000000, busy=0, seq_done=0; a request sampled after reset release restarts at L1/R1 with a full 3-cycle step.
6. BRAKE_OVERLAY_EN defined: brake=1 in IDLE → 111111; brake=1 plus left_req → 001111, 011111, 111111 per step; brake=1 during hazard → blink unchanged. Undefined: same stimulus → brake has no effect.
